// File: rtl/maxpool2x2_sequencer_if.sv
// Pixel-stream handshakes for the 2x2 max-pool sequencer: upstream pixels in, pooled pixels out.
interface maxpool2x2_sequencer_if;
  logic iVALID;
  logic iDATA;
  logic oREADY;
  logic oVALID;
  logic oDATA;
  logic iREADY;

  modport slave  (input iVALID, iDATA, iREADY, output oREADY, oVALID, oDATA);
  modport master (output iVALID, iDATA, iREADY, input oREADY, oVALID, oDATA);
endinterface

// File: rtl/maxpool2x2_sequencer.sv
// 2x2/stride-2 max pooling on a binary raster stream: buffers each even row, then ORs each
// 2x2 window while the following odd row streams in.
module maxpool2x2_sequencer #(
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  parameter int CW    = 5
) (
  input  logic                    iCLK,
  input  logic                    iRSTn,
  input  logic                    iCLR,
  input  logic                    iSTART,
  maxpool2x2_sequencer_if.slave   pix,
  output logic                    oBUSY,
  output logic                    oDONE
);

  typedef enum logic [2:0] {IDLE, EVEN, ODD, LAST, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_END = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ROW_PEN = CW'(IMG_H - 2);
  localparam bit            H_ODD   = (IMG_H % 2) == 1;

  state_t                state;
  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [(1<<CW)-1:0]    lineBuf;
  logic                  prev;

  logic                  accept;
  logic                  colEnd;
  logic [CW-1:0]         colPrev;
  logic                  vld_p0;
  logic                  pool_p0;

  function automatic logic poolOr(input logic a, input logic b, input logic c, input logic d);
    return a | b | c | d;
  endfunction

  // Stalling input while a result waits keeps the output register from being overwritten.
  assign pix.oREADY = (state == EVEN || state == ODD || state == LAST) &&
                      !(pix.oVALID && !pix.iREADY);
  assign accept  = pix.iVALID && pix.oREADY;
  assign colEnd  = (col == COL_END);
  assign colPrev = col - CW'(1);

  // Stage p0: window complete on the odd-row, odd-column accept
  assign vld_p0  = accept && (state == ODD) && col[0];
  assign pool_p0 = poolOr(lineBuf[colPrev], lineBuf[col], prev, pix.iDATA);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      lineBuf    <= '0;
      prev       <= 1'b0;
      pix.oVALID <= 1'b0;
      pix.oDATA  <= 1'b0;
      oDONE      <= 1'b0;
      oBUSY      <= 1'b0;
    end else if (iCLR) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      lineBuf    <= '0;
      prev       <= 1'b0;
      pix.oVALID <= 1'b0;
      pix.oDATA  <= 1'b0;
      oDONE      <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      oDONE <= 1'b0;

      // Stage p1: output register, reloadable in the same cycle it is taken
      if (vld_p0) begin
        pix.oVALID <= 1'b1;
        pix.oDATA  <= pool_p0;
      end else if (pix.oVALID && pix.iREADY) begin
        pix.oVALID <= 1'b0;
      end

      if (accept) begin
        if (state == EVEN) lineBuf[col] <= pix.iDATA;
        if (state == ODD && !col[0]) prev <= pix.iDATA;
        if (colEnd) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (iSTART) begin
            state <= EVEN;
            oBUSY <= 1'b1;
          end
        end
        EVEN: begin
          if (accept && colEnd) state <= (row == ROW_END) ? DRAIN : ODD;
        end
        ODD: begin
          if (accept && colEnd) begin
            if (row == ROW_END)                state <= DRAIN;
            else if (H_ODD && row == ROW_PEN)  state <= LAST;
            else                               state <= EVEN;
          end
        end
        LAST: begin
          if (accept && colEnd) state <= DRAIN;
        end
        DRAIN: begin
          if (!pix.oVALID || pix.iREADY) begin
            state <= DONE;
            oDONE <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          oBUSY <= 1'b0;
          col   <= '0;
          row   <= '0;
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2_sequencer.sv
// Scoreboard bench for maxpool2x2_sequencer: a 4x4 instance and a 5x5 (odd-size) instance.
module tb_maxpool2x2_sequencer;
  logic iCLK = 1'b0;
  logic iRSTn = 1'b0;
  logic clrA = 1'b0, startA = 1'b0, busyA, doneA;
  logic clrB = 1'b0, startB = 1'b0, busyB, doneB;

  maxpool2x2_sequencer_if ifA();
  maxpool2x2_sequencer_if ifB();

  maxpool2x2_sequencer #(.IMG_W(4), .IMG_H(4), .CW(3)) dutA (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(clrA), .iSTART(startA),
    .pix(ifA), .oBUSY(busyA), .oDONE(doneA));

  maxpool2x2_sequencer #(.IMG_W(5), .IMG_H(5), .CW(3)) dutB (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(clrB), .iSTART(startB),
    .pix(ifB), .oBUSY(busyB), .oDONE(doneB));

  always #5 iCLK = ~iCLK;

  int total = 0, bad = 0, cyc = 0;
  int accCnt[2], outCnt[2], doneCnt[2], lastXfer[2], doneCyc[2], lastAcc[2];
  bit hold[2];
  logic holdDat[2];
  logic expQ0[$];
  logic expQ1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monStep(input int s, input logic rst, input logic clr, input logic ivld,
                         input logic ordy, input logic ovld, input logic odat,
                         input logic irdy, input logic done);
    logic e;
    if (!rst) begin
      hold[s] = 1'b0;
      return;
    end
    if (ivld && ordy) begin
      accCnt[s]++;
      lastAcc[s] = cyc;
    end
    if (hold[s]) begin
      check("holdValid", ovld, 1);
      check("holdData", odat, holdDat[s]);
    end
    hold[s]    = ovld && !irdy && !clr;
    holdDat[s] = odat;
    if (ovld && irdy && !clr) begin
      outCnt[s]++;
      lastXfer[s] = cyc;
      if (s == 0 && expQ0.size() == 0) check("unexpectedOutA", 1, 0);
      else if (s == 1 && expQ1.size() == 0) check("unexpectedOutB", 1, 0);
      else begin
        if (s == 0) e = expQ0.pop_front();
        else        e = expQ1.pop_front();
        check(s == 0 ? "outDataA" : "outDataB", odat, e);
      end
    end
    if (done) begin
      doneCnt[s]++;
      doneCyc[s] = cyc;
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge iCLK) begin
    cyc++;
    monStep(0, iRSTn, clrA, ifA.iVALID, ifA.oREADY, ifA.oVALID, ifA.oDATA, ifA.iREADY, doneA);
    monStep(1, iRSTn, clrB, ifB.iVALID, ifB.oREADY, ifB.oVALID, ifB.oDATA, ifB.iREADY, doneB);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic setIn(input int s, input logic v, input logic d);
    if (s == 0) begin ifA.iVALID = v; ifA.iDATA = d; end
    else        begin ifB.iVALID = v; ifB.iDATA = d; end
  endtask

  task automatic sendPix(input int s, input logic d);
    logic rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    setIn(s, 1'b1, d);
    while (!rdy && n < 200) begin
      @(negedge iCLK);
      rdy = (s == 0) ? ifA.oREADY : ifB.oREADY;
      @(posedge iCLK);
      #1;
      n++;
    end
    if (!rdy) check("acceptTimeout", 0, 1);
    setIn(s, 1'b0, 1'b0);
  endtask

  task automatic startFrame(input int s);
    if (s == 0) startA = 1'b1; else startB = 1'b1;
    tick(1);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic sendFrame(input int s, input logic [63:0] px, input int n, input int startAt);
    for (int i = 0; i < n; i++) begin
      if (i == startAt) begin
        if (s == 0) startA = 1'b1; else startB = 1'b1;
      end
      sendPix(s, px[i]);
      startA = 1'b0;
      startB = 1'b0;
    end
  endtask

  task automatic pushExp(input int s, input logic [15:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      if (s == 0) expQ0.push_back(e[i]); else expQ1.push_back(e[i]);
    end
  endtask

  task automatic endCheck(input int s, input int o0, input int a0, input int d0,
                          input int nOut, input int nAcc);
    tick(10);
    check("outCount", outCnt[s] - o0, nOut);
    check("accCount", accCnt[s] - a0, nAcc);
    check("doneCount", doneCnt[s] - d0, 1);
    check("queueEmpty", (s == 0) ? expQ0.size() : expQ1.size(), 0);
  endtask

  initial begin
    int o0, a0, d0, c0, n;
    ifA.iVALID = 0; ifA.iDATA = 0; ifA.iREADY = 1;
    ifB.iVALID = 0; ifB.iDATA = 0; ifB.iREADY = 1;

    // Reset state
    tick(3);
    @(negedge iCLK);
    check("rstOValid", ifA.oVALID, 0);
    check("rstOData", ifA.oDATA, 0);
    check("rstODone", doneA, 0);
    check("rstOBusy", busyA, 0);
    check("rstOReady", ifA.oREADY, 0);
    @(posedge iCLK); #1;
    iRSTn = 1'b1;

    // iVALID without iSTART is never accepted
    setIn(0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      check("idleOReady", ifA.oREADY, 0);
      check("idleOBusy", busyA, 0);
    end
    @(posedge iCLK); #1;
    setIn(0, 1'b0, 1'b0);

    // 4x4 directed frame, rows 1000/0000/0011/0001
    o0 = outCnt[0]; a0 = accCnt[0]; d0 = doneCnt[0];
    pushExp(0, 16'b1001, 4);
    startFrame(0);
    c0 = cyc;
    sendFrame(0, 64'h8C01, 16, -1);
    check("acceptCycles", cyc - c0, 16);
    endCheck(0, o0, a0, d0, 4, 16);
    check("doneAfterXfer", doneCyc[0], lastXfer[0] + 1);

    // All-ones frame with the first result held off for 5 cycles
    o0 = outCnt[0]; a0 = accCnt[0]; d0 = doneCnt[0];
    ifA.iREADY = 1'b0;
    pushExp(0, 16'b1111, 4);
    startFrame(0);
    fork
      sendFrame(0, 64'hFFFF, 16, -1);
      begin
        n = 0;
        do begin @(negedge iCLK); n++; end while (!ifA.oVALID && n < 100);
        check("bpSawValid", ifA.oVALID, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge iCLK);
          check("bpOReadyLow", ifA.oREADY, 0);
          check("bpODataHeld", ifA.oDATA, 1);
        end
        @(posedge iCLK); #1;
        ifA.iREADY = 1'b1;
      end
    join
    endCheck(0, o0, a0, d0, 4, 16);

    // Abort after 6 accepts with a result pending, then a clean frame
    o0 = outCnt[0]; d0 = doneCnt[0];
    ifA.iREADY = 1'b0;
    startFrame(0);
    sendFrame(0, 64'h003F, 6, -1);
    clrA = 1'b1;
    tick(1);
    clrA = 1'b0;
    @(negedge iCLK);
    check("clrOValid", ifA.oVALID, 0);
    check("clrOBusy", busyA, 0);
    check("clrOReady", ifA.oREADY, 0);
    check("clrODone", doneA, 0);
    @(posedge iCLK); #1;
    ifA.iREADY = 1'b1;
    tick(5);
    check("clrNoDone", doneCnt[0] - d0, 0);
    check("clrNoOut", outCnt[0] - o0, 0);
    o0 = outCnt[0]; a0 = accCnt[0]; d0 = doneCnt[0];
    pushExp(0, 16'b0101, 4);
    startFrame(0);
    sendFrame(0, 64'h0120, 16, -1);
    endCheck(0, o0, a0, d0, 4, 16);

    // iSTART mid-frame is ignored
    o0 = outCnt[0]; a0 = accCnt[0]; d0 = doneCnt[0];
    pushExp(0, 16'b1001, 4);
    startFrame(0);
    sendFrame(0, 64'h8C01, 16, 5);
    endCheck(0, o0, a0, d0, 4, 16);

    // iCLR and iSTART together: stays idle
    clrA = 1'b1; startA = 1'b1;
    tick(1);
    clrA = 1'b0; startA = 1'b0;
    @(negedge iCLK);
    check("clrStartBusy", busyA, 0);
    check("clrStartReady", ifA.oREADY, 0);
    @(posedge iCLK); #1;

    // Asynchronous reset mid-frame, then a clean frame
    startFrame(0);
    sendFrame(0, 64'h7, 3, -1);
    #2 iRSTn = 1'b0;
    #1;
    check("asyncRstBusy", busyA, 0);
    check("asyncRstOValid", ifA.oVALID, 0);
    check("asyncRstOReady", ifA.oREADY, 0);
    @(posedge iCLK); #1;
    iRSTn = 1'b1;
    tick(1);
    o0 = outCnt[0]; a0 = accCnt[0]; d0 = doneCnt[0];
    pushExp(0, 16'b0110, 4);
    startFrame(0);
    sendFrame(0, 64'h1004, 16, -1);
    endCheck(0, o0, a0, d0, 4, 16);

    // 5x5: a lone 1 at (4,4) falls outside every window
    o0 = outCnt[1]; a0 = accCnt[1]; d0 = doneCnt[1];
    pushExp(1, 16'b0000, 4);
    startFrame(1);
    sendFrame(1, 64'h1 << 24, 25, -1);
    endCheck(1, o0, a0, d0, 4, 25);
    check("doneAfterAccepts", doneCyc[1] > lastAcc[1], 1);

    // 5x5: edge pixels (0,4) and (4,0) excluded, (3,3) pooled
    o0 = outCnt[1]; a0 = accCnt[1]; d0 = doneCnt[1];
    pushExp(1, 16'b1000, 4);
    startFrame(1);
    sendFrame(1, (64'h1 << 4) | (64'h1 << 18) | (64'h1 << 20), 25, -1);
    endCheck(1, o0, a0, d0, 4, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
